// File: rtl/zp_pkg.sv
// Shared types and sizing helpers for the zero-padding stream stage.
//   zp_state_e : frame sequencer states
//   out_rows   : padded frame height
//   out_cols   : padded frame width
//   cnt_width  : bits needed to hold values 0..n
package zp_pkg;

  typedef enum logic {
    ZP_IDLE = 1'b0,
    ZP_RUN  = 1'b1
  } zp_state_e;

  function automatic int unsigned out_rows(input int unsigned in_rows,
                                           input int unsigned pad_top,
                                           input int unsigned pad_bot);
    return in_rows + pad_top + pad_bot;
  endfunction

  function automatic int unsigned out_cols(input int unsigned in_cols,
                                           input int unsigned pad_left,
                                           input int unsigned pad_right);
    return in_cols + pad_left + pad_right;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/zp_pos_counter.sv
// Zero-based 2-D raster position counter (row r, column c).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear to (0,0), has priority over en
//   en       : advance one position (column first, wrapping into the next row)
//   r, c     : current row / column
//   eol      : c is the last column
//   eof      : last column of the last row
module zp_pos_counter
  import zp_pkg::*;
#(
  parameter int unsigned ROWS = 14,
  parameter int unsigned COLS = 17,
  localparam int unsigned RW  = cnt_width(ROWS),
  localparam int unsigned CW  = cnt_width(COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [RW-1:0] r,
  output logic [CW-1:0] c,
  output logic          eol,
  output logic          eof
);

  assign eol = (c == CW'(COLS - 1));
  assign eof = eol && (r == RW'(ROWS - 1));

  // Position register; wraps back to (0,0) after the last position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r <= '0;
      c <= '0;
    end else if (clr) begin
      r <= '0;
      c <= '0;
    end else if (en) begin
      if (eol) begin
        c <= '0;
        r <= eof ? '0 : r + RW'(1);
      end else begin
        c <= c + CW'(1);
      end
    end
  end

endmodule

// File: rtl/zero_pad_stream.sv
// Streams an IN_ROWS x IN_COLS frame from a show-ahead FIFO and surrounds it
// with independent top/bottom/left/right borders filled with PAD_VAL.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   start       : frame start pulse (honoured in IDLE and on the eof transfer)
//   in_data     : FIFO head word (show-ahead)
//   in_valid    : FIFO not empty
//   in_rdreq    : FIFO pop, only on an accepted interior beat
//   out_data    : padded stream word (combinational from FIFO head)
//   out_valid   : out_data valid
//   out_ready   : downstream accepts
//   out_sol     : beat is column 0
//   out_eol     : beat is the last column
//   out_eof     : beat is the last beat of the frame
//   busy        : frame in progress
//   frame_done  : registered one-cycle pulse after the eof transfer
module zero_pad_stream
  import zp_pkg::*;
#(
  parameter int unsigned WL        = 96,
  parameter int unsigned IN_ROWS   = 12,
  parameter int unsigned IN_COLS   = 15,
  parameter int unsigned PAD_TOP   = 1,
  parameter int unsigned PAD_BOT   = 1,
  parameter int unsigned PAD_LEFT  = 1,
  parameter int unsigned PAD_RIGHT = 1,
  parameter logic [WL-1:0] PAD_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [WL-1:0] in_data,
  input  logic          in_valid,
  output logic          in_rdreq,
  output logic [WL-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_sol,
  output logic          out_eol,
  output logic          out_eof,
  output logic          busy,
  output logic          frame_done
);

  localparam int unsigned OUT_ROWS = out_rows(IN_ROWS, PAD_TOP, PAD_BOT);
  localparam int unsigned OUT_COLS = out_cols(IN_COLS, PAD_LEFT, PAD_RIGHT);
  localparam int unsigned RW       = cnt_width(OUT_ROWS);
  localparam int unsigned CW       = cnt_width(OUT_COLS);

  zp_state_e       state_q;
  zp_state_e       state_d;
  logic [RW-1:0]   r;
  logic [CW-1:0]   c;
  logic            cnt_eol;
  logic            cnt_eof;
  logic            xfer;
  logic            row_lo;
  logic            row_hi;
  logic            col_lo;
  logic            col_hi;
  logic            interior;

  // Position within the padded frame; parked at (0,0) while idle.
  zp_pos_counter #(
    .ROWS (OUT_ROWS),
    .COLS (OUT_COLS)
  ) u_pos (
    .clk (clk),
    .rst (rst),
    .clr (state_q == ZP_IDLE),
    .en  (xfer),
    .r   (r),
    .c   (c),
    .eol (cnt_eol),
    .eof (cnt_eof)
  );

  // Interior window decode; a zero leading pad makes the lower bound trivially true.
  if (PAD_TOP == 0) begin : g_row_lo_open
    assign row_lo = 1'b1;
  end else begin : g_row_lo_cmp
    assign row_lo = (r >= RW'(PAD_TOP));
  end

  if (PAD_LEFT == 0) begin : g_col_lo_open
    assign col_lo = 1'b1;
  end else begin : g_col_lo_cmp
    assign col_lo = (c >= CW'(PAD_LEFT));
  end

  assign row_hi   = (r < RW'(PAD_TOP + IN_ROWS));
  assign col_hi   = (c < CW'(PAD_LEFT + IN_COLS));
  assign interior = row_lo && row_hi && col_lo && col_hi;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ZP_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and beat mux; pad beats never stall, interior beats wait on the FIFO.
  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    out_data  = PAD_VAL;
    in_rdreq  = 1'b0;
    xfer      = 1'b0;
    case (state_q)
      ZP_IDLE: begin
        if (start) begin
          state_d = ZP_RUN;
        end
      end
      ZP_RUN: begin
        if (interior) begin
          out_valid = in_valid;
          out_data  = in_data;
          in_rdreq  = in_valid & out_ready;
        end else begin
          out_valid = 1'b1;
        end
        xfer = out_valid & out_ready;
        // A start coinciding with the final transfer chains straight into the next frame.
        if (xfer && cnt_eof && !start) begin
          state_d = ZP_IDLE;
        end
      end
      default: begin
        state_d = ZP_IDLE;
      end
    endcase
  end

  assign busy    = (state_q == ZP_RUN);
  assign out_sol = busy && (c == '0);
  assign out_eol = busy && cnt_eol;
  assign out_eof = busy && cnt_eof;

  // End-of-frame pulse, one cycle after the eof transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= xfer && cnt_eof;
    end
  end

endmodule

// File: tb/tb_zero_pad_stream.sv
// Scoreboard bench: two instances (default 12x15 with unit pads; 4x4 with
// asymmetric pads and a non-zero fill value). Expected beats are queued when a
// frame is launched and popped by negedge monitors on every transfer.
module tb_zero_pad_stream;

  localparam int unsigned WA = 96;
  localparam int unsigned WB = 16;
  localparam logic [WB-1:0] PVB = 16'hBEEF;

  typedef struct packed {
    logic [95:0] d;
    logic        sol;
    logic        eol;
    logic        eof;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          a_start = 1'b0;
  logic [WA-1:0] a_in_data = '0;
  logic          a_in_valid = 1'b0;
  logic          a_rdreq;
  logic [WA-1:0] a_out_data;
  logic          a_out_valid;
  logic          a_ready = 1'b1;
  logic          a_sol, a_eol, a_eof, a_busy, a_fd;

  logic          b_start = 1'b0;
  logic [WB-1:0] b_in_data = '0;
  logic          b_in_valid = 1'b0;
  logic          b_rdreq;
  logic [WB-1:0] b_out_data;
  logic          b_out_valid;
  logic          b_ready = 1'b1;
  logic          b_sol, b_eol, b_eof, b_busy, b_fd;

  zero_pad_stream u_a (
    .clk(clk), .rst(rst), .start(a_start),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_rdreq(a_rdreq),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_ready),
    .out_sol(a_sol), .out_eol(a_eol), .out_eof(a_eof),
    .busy(a_busy), .frame_done(a_fd)
  );

  zero_pad_stream #(
    .WL(WB), .IN_ROWS(4), .IN_COLS(4), .PAD_TOP(2), .PAD_BOT(0),
    .PAD_LEFT(0), .PAD_RIGHT(3), .PAD_VAL(PVB)
  ) u_b (
    .clk(clk), .rst(rst), .start(b_start),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_rdreq(b_rdreq),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_ready),
    .out_sol(b_sol), .out_eol(b_eol), .out_eof(b_eof),
    .busy(b_busy), .frame_done(b_fd)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  function automatic logic [95:0] wa(input int k);
    return {32'(k), 32'hC0DE_0000 | 32'(k), ~32'(k)};
  endfunction

  function automatic logic [WB-1:0] wb(input int k);
    return 16'h1000 + 16'(k);
  endfunction

  // FIFO models (show-ahead)
  logic [WA-1:0] fifo_a[$];
  logic [WB-1:0] fifo_b[$];

  task automatic refresh_fifos();
    a_in_valid = (fifo_a.size() > 0);
    a_in_data  = (fifo_a.size() > 0) ? fifo_a[0] : '0;
    b_in_valid = (fifo_b.size() > 0);
    b_in_data  = (fifo_b.size() > 0) ? fifo_b[0] : '0;
  endtask

  always @(posedge clk) begin
    if (a_rdreq && fifo_a.size() > 0) void'(fifo_a.pop_front());
    if (b_rdreq && fifo_b.size() > 0) void'(fifo_b.pop_front());
    refresh_fifos();
  end

  task automatic load_a(input int base, input int n);
    for (int k = 0; k < n; k++) fifo_a.push_back(wa(base + k));
    refresh_fifos();
  endtask

  task automatic load_b(input int base, input int n);
    for (int k = 0; k < n; k++) fifo_b.push_back(wb(base + k));
    refresh_fifos();
  endtask

  beat_t exp_a[$];
  beat_t exp_b[$];

  // 14x17 frame: rows 1..12 and columns 1..15 are interior.
  task automatic push_frame_a(input int base);
    beat_t e;
    int k = 0;
    for (int r = 0; r < 14; r++)
      for (int c = 0; c < 17; c++) begin
        if (r >= 1 && r <= 12 && c >= 1 && c <= 15) begin
          e.d = wa(base + k);
          k++;
        end else begin
          e.d = '0;
        end
        e.sol = (c == 0);
        e.eol = (c == 16);
        e.eof = (r == 13 && c == 16);
        exp_a.push_back(e);
      end
  endtask

  // 6x7 frame: rows 2..5 and columns 0..3 are interior.
  task automatic push_frame_b(input int base);
    beat_t e;
    int k = 0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) begin
        if (r >= 2 && c <= 3) begin
          e.d = 96'(wb(base + k));
          k++;
        end else begin
          e.d = 96'(PVB);
        end
        e.sol = (c == 0);
        e.eol = (c == 6);
        e.eof = (r == 5 && c == 6);
        exp_b.push_back(e);
      end
  endtask

  // Monitor A
  beat_t         ea;
  bit            fd_exp_a = 1'b0;
  bit            stall_a = 1'b0;
  logic [WA-1:0] stall_d_a = '0;
  bit            hand_a = 1'b0;
  int            beat_a = 0;
  int            pops_a = 0;
  int            tot_a = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_a.delete();
      fd_exp_a = 1'b0;
      stall_a  = 1'b0;
      beat_a   = 0;
    end else begin
      chk("a_frame_done", 96'(a_fd), 96'(fd_exp_a));
      fd_exp_a = 1'b0;
      if (!a_busy) begin
        chk("a_idle_valid", 96'(a_out_valid), 96'(0));
        chk("a_idle_data", a_out_data, 96'(0));
      end
      if (a_rdreq) begin
        pops_a++;
        chk("a_pop_needs_xfer", 96'(a_out_valid && a_ready), 96'(1));
      end
      if (stall_a) begin
        chk("a_stall_valid", 96'(a_out_valid), 96'(1));
        chk("a_stall_data", a_out_data, stall_d_a);
      end
      stall_a   = a_out_valid && !a_ready;
      stall_d_a = a_out_data;
      if (a_out_valid && a_ready) begin
        tot_a++;
        if (exp_a.size() == 0) begin
          fail_now("a_unexpected_beat");
        end else begin
          ea = exp_a.pop_front();
          chk("a_data", a_out_data, ea.d);
          chk("a_markers", 96'({a_sol, a_eol, a_eof}), 96'({ea.sol, ea.eol, ea.eof}));
          if (ea.eof) fd_exp_a = 1'b1;
          if (hand_a) begin
            if (beat_a <= 16) chk("a_top_row_pad", a_out_data, 96'(0));
            if (beat_a == 18) chk("a_beat18_word0", a_out_data, wa(0));
            if (beat_a == 32) chk("a_beat32_word14", a_out_data, wa(14));
            if (beat_a == 237) chk("a_beat237_eof", 96'(a_eof), 96'(1));
          end
          beat_a = ea.eof ? 0 : beat_a + 1;
        end
      end
    end
  end

  // Monitor B
  beat_t eb;
  bit    fd_exp_b = 1'b0;
  int    beat_b = 0;
  int    pops_b = 0;
  int    tot_b = 0;
  int    first_pop_b = -1;

  always @(negedge clk) begin
    if (rst) begin
      exp_b.delete();
      fd_exp_b = 1'b0;
      beat_b   = 0;
    end else begin
      chk("b_frame_done", 96'(b_fd), 96'(fd_exp_b));
      fd_exp_b = 1'b0;
      if (!b_busy) chk("b_idle_data", 96'(b_out_data), 96'(PVB));
      if (b_rdreq) begin
        pops_b++;
        if (first_pop_b < 0) first_pop_b = beat_b;
        chk("b_pop_needs_xfer", 96'(b_out_valid && b_ready), 96'(1));
      end
      if (b_out_valid && b_ready) begin
        tot_b++;
        if (exp_b.size() == 0) begin
          fail_now("b_unexpected_beat");
        end else begin
          eb = exp_b.pop_front();
          chk("b_data", 96'(b_out_data), eb.d);
          chk("b_markers", 96'({b_sol, b_eol, b_eof}), 96'({eb.sol, eb.eol, eb.eof}));
          if (eb.eof) fd_exp_b = 1'b1;
          beat_b = eb.eof ? 0 : beat_b + 1;
        end
      end
    end
  end

  task automatic pulse_a();
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
  endtask

  task automatic pulse_b();
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
  endtask

  task automatic run_a(input bit rnd, input int budget, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      if (a_fd) seen = 1'b1;
      else if (rnd) a_ready = 1'($urandom_range(0, 1));
    end
    a_ready = 1'b1;
    if (!seen) fail_now({nm, "_frame_done_timeout"});
  endtask

  task automatic run_b(input int budget, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      if (b_fd) seen = 1'b1;
    end
    if (!seen) fail_now({nm, "_frame_done_timeout"});
  endtask

  task automatic wait_beat_a(input int n, input int budget, input string nm);
    int i = 0;
    while (beat_a < n && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    if (beat_a < n) fail_now({nm, "_beat_timeout"});
  endtask

  int p0;
  int t0;
  bit seen_eof;

  initial begin
    #1;
    chk("rst_busy", 96'(a_busy), 96'(0));
    chk("rst_valid", 96'(a_out_valid), 96'(0));
    chk("rst_frame_done", 96'(a_fd), 96'(0));
    chk("rst_rdreq", 96'(a_rdreq), 96'(0));
    chk("rst_data_pad", a_out_data, 96'(0));
    chk("rst_b_data_pad", 96'(b_out_data), 96'(PVB));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Default frame, always ready
    hand_a = 1'b1;
    p0 = pops_a; t0 = tot_a;
    load_a(0, 180);
    push_frame_a(0);
    pulse_a();
    run_a(1'b0, 400, "t1");
    hand_a = 1'b0;
    chk("t1_pops", 96'(pops_a - p0), 96'(180));
    chk("t1_transfers", 96'(tot_a - t0), 96'(238));

    // Same frame under random back-pressure
    p0 = pops_a;
    load_a(1000, 180);
    push_frame_a(1000);
    pulse_a();
    run_a(1'b1, 3000, "t2");
    chk("t2_pops", 96'(pops_a - p0), 96'(180));

    // FIFO empty at the first interior beat
    p0 = pops_a;
    push_frame_a(2000);
    pulse_a();
    wait_beat_a(18, 100, "t3");
    for (int i = 0; i < 5; i++) begin
      chk("t3_empty_valid", 96'(a_out_valid), 96'(0));
      chk("t3_empty_busy", 96'(a_busy), 96'(1));
      chk("t3_empty_rdreq", 96'(a_rdreq), 96'(0));
      @(posedge clk); #1;
    end
    chk("t3_hold_pos", 96'(beat_a), 96'(18));
    load_a(2000, 180);
    run_a(1'b0, 400, "t3");
    chk("t3_pops", 96'(pops_a - p0), 96'(180));

    // Back-to-back frames: start on the eof transfer
    p0 = pops_a;
    load_a(3000, 360);
    push_frame_a(3000);
    push_frame_a(3180);
    pulse_a();
    seen_eof = 1'b0;
    for (int i = 0; i < 400 && !seen_eof; i++) begin
      if (a_out_valid && a_ready && a_eof) seen_eof = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!seen_eof) fail_now("t4_eof_timeout");
    a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
    chk("t4_no_idle_busy", 96'(a_busy), 96'(1));
    chk("t4_next_sol", 96'(a_sol), 96'(1));
    run_a(1'b0, 400, "t4");
    chk("t4_pops", 96'(pops_a - p0), 96'(360));

    // Mid-frame start ignored, then asynchronous reset at beat 100
    load_a(4000, 180);
    push_frame_a(4000);
    pulse_a();
    wait_beat_a(50, 100, "t5a");
    pulse_a();
    wait_beat_a(100, 100, "t5b");
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", 96'(a_busy), 96'(0));
    chk("t5_rst_valid", 96'(a_out_valid), 96'(0));
    chk("t5_rst_rdreq", 96'(a_rdreq), 96'(0));
    fifo_a.delete();
    refresh_fifos();
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    p0 = pops_a; t0 = tot_a;
    load_a(5000, 180);
    push_frame_a(5000);
    pulse_a();
    run_a(1'b0, 400, "t5");
    chk("t5_pops", 96'(pops_a - p0), 96'(180));
    chk("t5_transfers", 96'(tot_a - t0), 96'(238));

    // Asymmetric pads, 4x4 -> 6x7
    load_b(0, 16);
    push_frame_b(0);
    pulse_b();
    run_b(100, "t6");
    chk("t6_first_pop_beat", 96'(first_pop_b), 96'(14));
    chk("t6_pops", 96'(pops_b), 96'(16));
    chk("t6_transfers", 96'(tot_b), 96'(42));

    @(posedge clk); #1;
    chk("end_a_queue_empty", 96'(exp_a.size()), 96'(0));
    chk("end_b_queue_empty", 96'(exp_b.size()), 96'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
